// File: rtl/enc_quad_cnt_if.sv
// rtl/enc_quad_cnt_if.sv - control, encoder-pin and count/readout signals for enc_quad_cnt
interface enc_quad_cnt_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 64
);
    logic                    I_ARM;
    logic                    I_CLR;
    logic [N_CH-1:0]         I_A;
    logic [N_CH-1:0]         I_B;
    logic [N_CH-1:0]         I_Z;
    logic [N_CH*CNT_W-1:0]   O_CNT;
    logic [N_CH-1:0]         O_DIR;
    logic [N_CH*CNT_W-1:0]   O_IDX_CNT;
    logic [N_CH-1:0]         O_IDX_VLD;
    logic [N_CH-1:0]         O_ERR;

    modport master (
        output I_ARM, I_CLR, I_A, I_B, I_Z,
        input  O_CNT, O_DIR, O_IDX_CNT, O_IDX_VLD, O_ERR
    );

    modport slave (
        input  I_ARM, I_CLR, I_A, I_B, I_Z,
        output O_CNT, O_DIR, O_IDX_CNT, O_IDX_VLD, O_ERR
    );
endinterface

// File: rtl/enc_quad_cnt.sv
// rtl/enc_quad_cnt.sv - multi-channel x4 quadrature counter with sync, glitch filter, index capture
// Optional feature macro ENC_Z_RESET_EN: an armed index rising edge also zeroes that channel's count.
module enc_quad_cnt #(
    parameter int N_CH        = 2,
    parameter int CNT_W       = 64,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input logic           CLK,
    input logic           RST_N,
    enc_quad_cnt_if.slave bus
);
    localparam int         NP = 3 * N_CH;
    localparam logic [3:0] FL = 4'(FILT_LEN);

    // Pin p = 3*ch + {0:A, 1:B, 2:Z}
    logic [NP-1:0] raw;
    logic [NP-1:0] filt;
    logic [NP-1:0] stl;

    // Position of a state along the forward cycle 00->10->11->01
    function automatic logic [1:0] qpos(input logic [1:0] s);
        return {s[0], s[1] ^ s[0]};
    endfunction

    for (genvar p = 0; p < NP; p++) begin : g_pin
        logic [SYNC_STAGES-1:0] sync_q;
        logic [3:0]             diff_q, same_q;
        logic                   filt_q, stl_q;
        logic                   smp;
        logic [3:0]             diff_d, same_d;

        assign smp    = sync_q[SYNC_STAGES-1];
        assign diff_d = diff_q + 4'd1;
        assign same_d = same_q + 4'd1;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                sync_q <= '0;
                diff_q <= '0;
                same_q <= '0;
                filt_q <= 1'b0;
                stl_q  <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw[p]};
                if (smp != filt_q) begin
                    same_q <= '0;
                    if (diff_d >= FL) begin
                        filt_q <= smp;
                        diff_q <= '0;
                        stl_q  <= 1'b1;
                    end else begin
                        diff_q <= diff_d;
                    end
                end else begin
                    diff_q <= '0;
                    // A pin that never toggles still has to be declared settled for init
                    if (!stl_q) begin
                        if (same_d >= FL) begin
                            stl_q  <= 1'b1;
                            same_q <= '0;
                        end else begin
                            same_q <= same_d;
                        end
                    end
                end
            end
        end

        assign filt[p] = filt_q;
        assign stl[p]  = stl_q;
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [1:0]       cur, prev_q, delta;
        logic             init_q, zprev_q, dir_q, err_q, vld_q;
        logic [CNT_W-1:0] cnt_q, idx_q;
        logic             step_up, step_dn, bad, z_rise, z_zero;

        assign raw[3*c +: 3] = {bus.I_Z[c], bus.I_B[c], bus.I_A[c]};
        assign cur           = {filt[3*c], filt[3*c+1]};

        always_comb begin
            delta   = qpos(cur) - qpos(prev_q);
            step_up = init_q && (delta == 2'd1);
            step_dn = init_q && (delta == 2'd3);
            bad     = init_q && (delta == 2'd2);
            z_rise  = bus.I_ARM && stl[3*c+2] && filt[3*c+2] && !zprev_q;
`ifdef ENC_Z_RESET_EN
            z_zero  = z_rise;
`else
            z_zero  = 1'b0;
`endif
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                prev_q  <= 2'b00;
                init_q  <= 1'b0;
                zprev_q <= 1'b0;
                dir_q   <= 1'b0;
                err_q   <= 1'b0;
                vld_q   <= 1'b0;
                cnt_q   <= '0;
                idx_q   <= '0;
            end else begin
                zprev_q <= filt[3*c+2];
                if (!init_q) begin
                    if (stl[3*c] && stl[3*c+1]) begin
                        prev_q <= cur;
                        init_q <= 1'b1;
                    end
                end else begin
                    prev_q <= cur;
                end

                if (bus.I_CLR) begin
                    cnt_q  <= '0;
                    idx_q  <= '0;
                    err_q  <= 1'b0;
                    vld_q  <= 1'b0;
                    init_q <= 1'b0;
                end else begin
                    vld_q <= z_rise;
                    if (bad)    err_q <= 1'b1;
                    if (z_rise) idx_q <= cnt_q;
                    if (z_zero) begin
                        cnt_q <= '0;
                    end else if (bus.I_ARM && step_up) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        dir_q <= 1'b1;
                    end else if (bus.I_ARM && step_dn) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        dir_q <= 1'b0;
                    end
                end
            end
        end

        assign bus.O_CNT[c*CNT_W +: CNT_W]     = cnt_q;
        assign bus.O_IDX_CNT[c*CNT_W +: CNT_W] = idx_q;
        assign bus.O_DIR[c]                    = dir_q;
        assign bus.O_ERR[c]                    = err_q;
        assign bus.O_IDX_VLD[c]                = vld_q;
    end
endmodule

// File: tb/tb_enc_quad_cnt.sv
// tb/tb_enc_quad_cnt.sv - self-checking bench for enc_quad_cnt (64-bit dual channel plus 8-bit single channel)
module tb_enc_quad_cnt;
    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    enc_quad_cnt_if #(.N_CH(2), .CNT_W(64)) bus ();
    enc_quad_cnt_if #(.N_CH(1), .CNT_W(8))  bus8 ();

    assign bus8.I_ARM = bus.I_ARM;
    assign bus8.I_CLR = bus.I_CLR;
    assign bus8.I_A   = bus.I_A[0:0];
    assign bus8.I_B   = bus.I_B[0:0];
    assign bus8.I_Z   = bus.I_Z[0:0];

    enc_quad_cnt #(.N_CH(2), .CNT_W(64), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
        .CLK(CLK), .RST_N(RST_N), .bus(bus)
    );
    enc_quad_cnt #(.N_CH(1), .CNT_W(8), .SYNC_STAGES(2), .FILT_LEN(3)) dut8 (
        .CLK(CLK), .RST_N(RST_N), .bus(bus8)
    );

    int     ncomp = 0;
    int     nfail = 0;
    int     ph[2]       = '{0, 0};
    longint ecnt[2]     = '{0, 0};
    longint eidx[2]     = '{0, 0};
    logic   edir[2]     = '{1'b0, 1'b0};
    logic   eerr[2]     = '{1'b0, 1'b0};
    int     evld[2]     = '{0, 0};
    int     vld_seen[2] = '{0, 0};
    logic   arm = 1'b0;

    always @(negedge CLK)
        for (int c = 0; c < 2; c++)
            if (bus.O_IDX_VLD[c] === 1'b1) vld_seen[c]++;

    task automatic wt(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic verify(input string tag);
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("%s/cnt%0d", tag, c), bus.O_CNT[c*64 +: 64], 64'(ecnt[c]));
            chk($sformatf("%s/dir%0d", tag, c), 64'(bus.O_DIR[c]), 64'(edir[c]));
            chk($sformatf("%s/err%0d", tag, c), 64'(bus.O_ERR[c]), 64'(eerr[c]));
            chk($sformatf("%s/idx%0d", tag, c), bus.O_IDX_CNT[c*64 +: 64], 64'(eidx[c]));
            chk($sformatf("%s/vld%0d", tag, c), 64'(vld_seen[c]), 64'(evld[c]));
        end
        chk({tag, "/cnt8"}, 64'(bus8.O_CNT), 64'(ecnt[0][7:0]));
    endtask

    task automatic drive_ab(input int c);
        bus.I_A[c] = (ph[c] == 1 || ph[c] == 2);
        bus.I_B[c] = (ph[c] >= 2);
    endtask

    // Model of the count: phase advance by one quadrature state is one count in that direction
    task automatic step(input int c, input bit up, input bit z);
        ph[c] = up ? (ph[c] + 1) % 4 : (ph[c] + 3) % 4;
        drive_ab(c);
        if (z) bus.I_Z[c] = 1'b1;
        if (arm) begin
            if (z) begin
                eidx[c] = ecnt[c];
                evld[c]++;
            end
`ifdef ENC_Z_RESET_EN
            if (z) ecnt[c] = 0;
            else begin
                ecnt[c] += up ? 1 : -1;
                edir[c] = up;
            end
`else
            ecnt[c] += up ? 1 : -1;
            edir[c] = up;
`endif
        end
        wt(8);
        if (z) begin
            bus.I_Z[c] = 1'b0;
            wt(8);
        end
    endtask

    task automatic zpulse(input int c);
        bus.I_Z[c] = 1'b1;
        if (arm) begin
            eidx[c] = ecnt[c];
            evld[c]++;
`ifdef ENC_Z_RESET_EN
            ecnt[c] = 0;
`endif
        end
        wt(8);
        bus.I_Z[c] = 1'b0;
        wt(8);
    endtask

    task automatic clr();
        bus.I_CLR = 1'b1;
        wt(1);
        bus.I_CLR = 1'b0;
        for (int c = 0; c < 2; c++) begin
            ecnt[c] = 0;
            eidx[c] = 0;
            eerr[c] = 1'b0;
        end
        wt(4);
    endtask

    initial begin
        RST_N     = 1'b0;
        bus.I_ARM = 1'b0;
        bus.I_CLR = 1'b0;
        bus.I_A   = '0;
        bus.I_B   = '0;
        bus.I_Z   = '0;
        wt(3);
        chk("rst/cnt", bus.O_CNT[63:0], 64'd0);
        chk("rst/idx", bus.O_IDX_CNT[63:0], 64'd0);
        chk("rst/flags", 64'({bus.O_DIR, bus.O_ERR, bus.O_IDX_VLD}), 64'd0);
        RST_N = 1'b1;
        wt(20);
        verify("idle");
        arm = 1'b1;
        bus.I_ARM = 1'b1;
        wt(2);

        // First forward edge: count must move on exactly the 6th rising edge
        ph[0] = 1;
        drive_ab(0);
        ecnt[0] = 1;
        edir[0] = 1'b1;
        wt(5);
        chk("lat5", bus.O_CNT[63:0], 64'd0);
        wt(1);
        chk("lat6", bus.O_CNT[63:0], 64'd1);
        wt(2);
        for (int i = 0; i < 39; i++) step(0, 1'b1, 1'b0);
        verify("fwd40");

        clr();
        verify("clr0");
        for (int i = 0; i < 20; i++) step(0, 1'b0, 1'b0);
        verify("rev20");
        chk("rev20/raw", bus.O_CNT[63:0], 64'hFFFF_FFFF_FFFF_FFEC);

        bus.I_A[0] = ~bus.I_A[0];
        wt(2);
        bus.I_A[0] = ~bus.I_A[0];
        wt(10);
        bus.I_Z[0] = 1'b1;
        wt(2);
        bus.I_Z[0] = 1'b0;
        wt(10);
        verify("glitch");

        for (int i = 0; i < 57; i++) step(0, 1'b1, 1'b0);
        verify("c37");
        step(0, 1'b1, 1'b1);
        verify("zidx");
        chk("zidx/raw", bus.O_IDX_CNT[63:0], 64'd37);

        ph[0] = (ph[0] + 2) % 4;
        drive_ab(0);
        eerr[0] = 1'b1;
        wt(8);
        verify("err");
        wt(8);
        verify("sticky");
        clr();
        verify("errclr");

        for (int i = 0; i < 127; i++) step(0, 1'b1, 1'b0);
        verify("w127");
        step(0, 1'b1, 1'b0);
        verify("w128");
        chk("wrap8", 64'(bus8.O_CNT), 64'h80);
        arm = 1'b0;
        bus.I_ARM = 1'b0;
        wt(2);
        for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0);
        arm = 1'b1;
        bus.I_ARM = 1'b1;
        wt(10);
        verify("rearm");
        step(0, 1'b0, 1'b0);
        verify("rearm_step");

        for (int i = 0; i < 80; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 7) step($urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'b0);
            else if (r == 7) zpulse($urandom_range(0, 1));
            else begin
                arm = ~arm;
                bus.I_ARM = arm;
                wt(2);
            end
            verify($sformatf("rnd%0d", i));
        end

        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("mrst/cnt0", bus.O_CNT[63:0], 64'd0);
        chk("mrst/cnt1", bus.O_CNT[127:64], 64'd0);
        chk("mrst/idx", bus.O_IDX_CNT[63:0], 64'd0);
        chk("mrst/flags", 64'({bus.O_DIR, bus.O_ERR, bus.O_IDX_VLD}), 64'd0);
        chk("mrst/cnt8", 64'(bus8.O_CNT), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule

// File: doc/enc_quad_cnt.md
Name: enc_quad_cnt

Overview:
Multi-channel quadrature encoder counter. It is the parametrised successor of the single-phase A-pulse encoder counter used in the DAQ front end. Each channel decodes A/B in x4 mode into a signed up/down count of configurable width. Each channel has input synchronisers, a glitch filter, index (Z) capture, direction indication and an illegal-transition flag. It sits between the encoder input pins and the DAQ sample/readout logic, in the same position as the existing encoder count path.

Parameters:
N_CH, 2, number of encoder channels (1..8)
CNT_W, 64, count width per channel in bits (8..64)
SYNC_STAGES, 2, synchroniser flops per input (2..3)
FILT_LEN, 3, consecutive equal synchronised samples required before a filtered input changes (1..15)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  asynchronous active-low reset; deassertion is synchronised externally
I_ARM  in  1  counting enable, common to all channels (synchronous, level)
I_CLR  in  1  synchronous clear of all counts, index latches and error flags (one-cycle pulse or level)
I_A  in  N_CH  phase A per channel (asynchronous)
I_B  in  N_CH  phase B per channel (asynchronous)
I_Z  in  N_CH  index per channel (asynchronous)
O_CNT  out  N_CH*CNT_W  signed two's-complement count; channel k is at bits [k*CNT_W +: CNT_W]
O_DIR  out  N_CH  last step direction per channel: 1 = up, 0 = down
O_IDX_CNT  out  N_CH*CNT_W  count captured at the last Z rising edge; packed like O_CNT
O_IDX_VLD  out  N_CH  one-cycle pulse when O_IDX_CNT of that channel updates
O_ERR  out  N_CH  sticky illegal-transition flag per channel

Behaviour:
- Reset (RST_N=0, asynchronous): all outputs are 0. Synchronisers, filters, previous-state registers and init flags are 0.
- Input path per pin: SYNC_STAGES-flop synchroniser, then a filter.
  - The filter counter reloads when the synchronised value differs from the filtered value.
  - The filtered value takes the new level once the level has been seen FILT_LEN consecutive cycles.
- Init: per channel, the first cycle after reset in which the filtered A and B are both settled (FILT_LEN samples) loads the previous-state register. This produces no count and no error. Channel init also re-runs after I_CLR.
- Decode (x4), using state {A,B}:
  - 00->10->11->01->00 is +1, O_DIR=1.
  - The reverse sequence is -1, O_DIR=0.
  - No change means no action.
  - A change of both bits in the same filtered update means: no count, set O_ERR, and the previous state is still updated.
- Latency: a clean A or B edge is reflected in O_CNT exactly SYNC_STAGES+FILT_LEN+1 rising edges after the first edge that samples the new level. With defaults this is 6.
- I_ARM=0:
  - Count, O_DIR and the index capture are frozen.
  - Synchronisers, filters and the previous state keep tracking, so re-arming never produces a spurious step.
  - O_ERR still sets.
- Wrap: counts are modulo 2^CNT_W. Max positive +1 gives min negative; 0 -1 gives all-ones. No saturation and no flag.
- Index:
  - On a filtered Z rising edge while armed, O_IDX_CNT takes the count value before any same-cycle step, and O_IDX_VLD pulses for 1 cycle.
  - Z held high produces no repeat pulse.
  - A Z edge while disarmed is ignored.
- Priority per cycle: I_CLR > Z reset (optional feature) > step.
  - I_CLR zeroes O_CNT, O_IDX_CNT and O_ERR, and suppresses the step and O_IDX_VLD in that cycle.
  - O_DIR holds its value through I_CLR.
- Channels are fully independent apart from I_ARM and I_CLR.
- Reset mid-operation: all state returns to reset values immediately. Filter history is discarded, so the init step repeats after reset release.

Optional Feature:
ENC_Z_RESET_EN
- Defined: a filtered Z rising edge while armed sets that channel's count to 0 in the same cycle as the index capture.
  - O_IDX_CNT still captures the pre-reset value.
  - A coincident A/B step is discarded, so the count becomes exactly 0.
- Undefined: Z only captures and pulses; the count is never modified by Z.

Test Plan:
- Defaults, reset, settle, arm, 10 forward quadrature cycles (40 edges), edges spaced 8 clocks apart -> O_CNT0=40, O_DIR0=1; first increment exactly 6 edges after the first A sample.
- Same channel, 5 reverse cycles from 0 -> O_CNT0=-20 (0xFFFF_FFFF_FFFF_FFEC), O_DIR0=0; channel 1 stays 0 throughout.
- Two-cycle glitches on A and on Z with FILT_LEN=3 -> no count change, no O_IDX_VLD.
- Count to 37, then Z pulse coincident with a forward step -> O_IDX_CNT0=37 and O_IDX_VLD0 pulses once. Without the macro O_CNT0=38; with ENC_Z_RESET_EN, O_CNT0=0.
- Toggle A and B together (00->11) -> O_ERR0=1 and sticky, count unchanged; I_CLR -> O_ERR0=0, O_CNT0=0, O_IDX_CNT0=0.
- CNT_W=8: count to 127, one forward step -> -128 (0x80); disarm, 4 steps, re-arm -> count unchanged and no step on re-arm.
